// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types for the uart_rx framing controller: SOF marker, parser and handshake
// state encodings, and the error codes reported on err_code.
package uart_frame_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CKSUM   = 2'd3
    } parse_state_e;

    typedef enum logic {
        HS_WAIT = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BADLEN  = 2'd1,
        ERR_CKSUM   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Bundle of the uart_rx byte handshake, the payload stream and the frame status.
// The controller uses the slave modport; the byte source / payload sink side uses master.
interface uart_rx_frame_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ack;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_last;
    logic       pl_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    modport master (
        output rx_data, rx_ready, pl_ready,
        input  rx_ack, pl_data, pl_valid, pl_last, frame_ok, frame_err, err_code
    );

    modport slave (
        input  rx_data, rx_ready, pl_ready,
        output rx_ack, pl_data, pl_valid, pl_last, frame_ok, frame_err, err_code
    );
endinterface

// File: rtl/uart_rx_frame_ctrl_hs.sv
// 4-phase ready/ack handshake towards uart_rx; strobes the byte to the parser in the
// capture cycle.  state | meaning:  HS_WAIT | idle, may capture  --  HS_ACK | ack held until ready drops
module uart_rx_hs
    import uart_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst_l,
    input  logic [7:0] rx_data_i,
    input  logic       rx_ready_i,
    input  logic       slot_free_i,
    output logic       rx_ack_o,
    output logic       byte_stb_o,
    output logic [7:0] byte_o
);

    hs_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= HS_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HS_WAIT: if (rx_ready_i && slot_free_i) state_d = HS_ACK;
            HS_ACK:  if (!rx_ready_i) state_d = HS_WAIT;
            default: state_d = HS_WAIT;
        endcase
    end

    always_comb begin
        rx_ack_o   = (state_q == HS_ACK);
        byte_stb_o = (state_q == HS_WAIT) && rx_ready_i && slot_free_i;
        byte_o     = rx_data_i;
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser [SOF][LEN][PAYLOAD x LEN][CKSUM] on top of the uart_rx handshake; streams
// payload with valid/ready and pulses frame_ok/frame_err. Macro UART_FRAME_CKSUM_EN adds the CKSUM byte.
//   state   | meaning
//   HUNT    | waiting for SOF, other bytes dropped
//   LEN     | next byte is payload length
//   PAYLOAD | forwarding payload bytes
//   CKSUM   | next byte closes the frame (checksum build only)
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN     = 64,
    parameter int TIMEOUT_CYC = 208340
) (
    input  logic                 clk,
    input  logic                 rst_l,
    uart_rx_frame_ctrl_if.slave  bus
);

    localparam int             TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  TMO_LOAD  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

    logic         byte_stb;
    logic [7:0]   rx_byte;
    logic         slot_free;
    logic         len_bad;
    logic         last_pl;
    logic         tmo_hit;

    parse_state_e state_q, state_d;
    logic [7:0]   len_q, len_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]   pl_data_q, pl_data_d;
    logic         pl_valid_q, pl_valid_d;
    logic         pl_last_q, pl_last_d;
    logic         ok_q, ok_d;
    logic         err_q, err_d;
    err_code_e    code_q, code_d;
`ifdef UART_FRAME_CKSUM_EN
    logic [7:0]   sum_q, sum_d;
    logic [7:0]   ck_sum;
    assign ck_sum = sum_q + rx_byte;
`endif

    // Back-pressure: a payload byte still waiting downstream blocks the next capture.
    assign slot_free = !(pl_valid_q && !bus.pl_ready);
    assign len_bad   = (rx_byte == 8'd0) || (rx_byte > MAX_LEN_B);
    assign last_pl   = (cnt_q + 8'd1) == len_q;
    assign tmo_hit   = (state_q != HUNT) && !byte_stb && slot_free && (tmo_q == '0);

    uart_rx_hs u_hs (
        .clk         (clk),
        .rst_l       (rst_l),
        .rx_data_i   (bus.rx_data),
        .rx_ready_i  (bus.rx_ready),
        .slot_free_i (slot_free),
        .rx_ack_o    (bus.rx_ack),
        .byte_stb_o  (byte_stb),
        .byte_o      (rx_byte)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= HUNT;
            len_q      <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            pl_data_q  <= '0;
            pl_valid_q <= 1'b0;
            pl_last_q  <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
`ifdef UART_FRAME_CKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            pl_data_q  <= pl_data_d;
            pl_valid_q <= pl_valid_d;
            pl_last_q  <= pl_last_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            code_q     <= code_d;
`ifdef UART_FRAME_CKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (byte_stb) begin
            case (state_q)
                HUNT:    if (rx_byte == SOF_BYTE) state_d = LEN;
                LEN:     state_d = len_bad ? HUNT : PAYLOAD;
`ifdef UART_FRAME_CKSUM_EN
                PAYLOAD: if (last_pl) state_d = CKSUM;
`else
                PAYLOAD: if (last_pl) state_d = HUNT;
`endif
                default: state_d = HUNT;
            endcase
        end else if (tmo_hit) begin
            state_d = HUNT;
        end
    end

    always_comb begin
        len_d      = len_q;
        cnt_d      = cnt_q;
        pl_data_d  = pl_data_q;
        pl_valid_d = pl_valid_q && !bus.pl_ready;
        pl_last_d  = pl_valid_d ? pl_last_q : 1'b0;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        code_d     = code_q;
`ifdef UART_FRAME_CKSUM_EN
        sum_d      = sum_q;
`endif
        tmo_d      = tmo_q;
        if (byte_stb || state_q == HUNT) begin
            tmo_d = TMO_LOAD;
        end else if (slot_free && tmo_q != '0) begin
            tmo_d = tmo_q - TW'(1);
        end

        if (byte_stb) begin
            case (state_q)
                LEN: begin
                    if (len_bad) begin
                        err_d  = 1'b1;
                        code_d = ERR_BADLEN;
                    end else begin
                        len_d = rx_byte;
                        cnt_d = '0;
`ifdef UART_FRAME_CKSUM_EN
                        sum_d = rx_byte;
`endif
                    end
                end
                PAYLOAD: begin
                    pl_data_d  = rx_byte;
                    pl_valid_d = 1'b1;
                    pl_last_d  = last_pl;
                    cnt_d      = cnt_q + 8'd1;
`ifdef UART_FRAME_CKSUM_EN
                    sum_d      = sum_q + rx_byte;
`else
                    if (last_pl) begin
                        ok_d   = 1'b1;
                        code_d = ERR_NONE;
                    end
`endif
                end
`ifdef UART_FRAME_CKSUM_EN
                CKSUM: begin
                    if (ck_sum == 8'h00) begin
                        ok_d   = 1'b1;
                        code_d = ERR_NONE;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_CKSUM;
                    end
                end
`endif
                default: ;
            endcase
        end else if (tmo_hit) begin
            err_d  = 1'b1;
            code_d = ERR_TIMEOUT;
        end
    end

    assign bus.pl_data   = pl_data_q;
    assign bus.pl_valid  = pl_valid_q;
    assign bus.pl_last   = pl_last_q;
    assign bus.frame_ok  = ok_q;
    assign bus.frame_err = err_q;
    assign bus.err_code  = code_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: frame table plus back-pressure and reset
// sequences, with payload and frame-result scoreboards. Follows UART_FRAME_CKSUM_EN.
module tb_uart_rx_frame_ctrl;

    localparam int TMO     = 200;
    localparam int MAXLEN  = 4;
`ifdef UART_FRAME_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    typedef struct {
        logic [63:0] bytes;     // first byte in bits 63:56
        int          nb;
        bit          has_ck;    // last byte is a checksum (dropped without checksum build)
        int          pl_first;
        int          pl_n;
        bit          tmo;
        bit          exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    typedef struct { logic [7:0] d; bit last; } pl_exp_t;
    typedef struct { bit err; logic [1:0] code; } res_exp_t;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    int   checks = 0;
    int   failures = 0;

    pl_exp_t  pl_q[$];
    res_exp_t res_q[$];
    vec_t     tv[8];

    uart_rx_frame_ctrl_if bus ();

    uart_rx_frame_ctrl #(.MAX_LEN(MAXLEN), .TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_pl(input logic [7:0] d, input bit last);
        pl_exp_t e;
        e.d = d;
        e.last = last;
        pl_q.push_back(e);
    endtask

    task automatic push_res(input bit err, input logic [1:0] code);
        res_exp_t r;
        r.err = err;
        r.code = code;
        res_q.push_back(r);
    endtask

    // Called at a negedge; returns at a negedge after a full 4-phase handshake.
    task automatic send_byte(input logic [7:0] b, input int budget);
        int n;
        chk("ack_idle", int'(bus.rx_ack), 0);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        n = 0;
        while (bus.rx_ack !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("ack_rise", int'(bus.rx_ack), 1);
        bus.rx_ready = 1'b0;
        @(negedge clk);
        chk("ack_fall", int'(bus.rx_ack), 0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ack"}, int'(bus.rx_ack), 0);
        chk({tag, "_pl_valid"}, int'(bus.pl_valid), 0);
        chk({tag, "_pl_last"}, int'(bus.pl_last), 0);
        chk({tag, "_pl_data"}, int'(bus.pl_data), 0);
        chk({tag, "_frame_ok"}, int'(bus.frame_ok), 0);
        chk({tag, "_frame_err"}, int'(bus.frame_err), 0);
        chk({tag, "_err_code"}, int'(bus.err_code), 0);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_pl_left"}, pl_q.size(), 0);
        chk({tag, "_res_left"}, res_q.size(), 0);
        pl_q.delete();
        res_q.delete();
    endtask

    // Monitor: sampled 1 time unit after the negedge so bench drives have settled.
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;
    always @(negedge clk) begin : mon
        pl_exp_t  e;
        res_exp_t r;
        #1;
        if (!rst_l) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v && bus.pl_valid) chk("pl_data_stable", int'(bus.pl_data), int'(hold_d));
            hold_v <= bus.pl_valid && !bus.pl_ready;
            hold_d <= bus.pl_data;
            if (bus.pl_valid && bus.pl_ready) begin
                if (pl_q.size() == 0) begin
                    chk("pl_unexpected", int'(bus.pl_data), -1);
                end else begin
                    e = pl_q.pop_front();
                    chk("pl_data", int'(bus.pl_data), int'(e.d));
                    chk("pl_last", int'(bus.pl_last), int'(e.last));
                end
            end
            if (bus.frame_ok || bus.frame_err) begin
                chk("ok_err_exclusive", int'(bus.frame_ok && bus.frame_err), 0);
                if (res_q.size() == 0) begin
                    chk("pulse_unexpected", int'({bus.frame_ok, bus.frame_err}), 0);
                end else begin
                    r = res_q.pop_front();
                    chk("frame_err", int'(bus.frame_err), int'(r.err));
                    chk("frame_ok", int'(bus.frame_ok), int'(!r.err));
                    chk("err_code", int'(bus.err_code), int'(r.code));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int acks;
        logic [7:0] b;

        // Checksums make LEN + payload + CK sum to zero mod 256.
        tv[0] = '{64'hA5_03_11_22_33_97_00_00, 6, 1'b1, 2, 3, 1'b0, 1'b0, 2'd0};
        tv[1] = '{64'hA5_02_10_20_00_00_00_00, 5, 1'b1, 2, 2, 1'b0, CK_EN, CK_EN ? 2'd2 : 2'd0};
        tv[2] = '{64'h55_A5_00_00_00_00_00_00, 3, 1'b0, 0, 0, 1'b0, 1'b1, 2'd1};
        tv[3] = '{64'hA5_01_7E_81_00_00_00_00, 4, 1'b1, 2, 1, 1'b0, 1'b0, 2'd0};
        tv[4] = '{64'hA5_05_00_00_00_00_00_00, 2, 1'b0, 0, 0, 1'b0, 1'b1, 2'd1};
        tv[5] = '{64'hA5_04_01_02_03_04_F2_00, 7, 1'b1, 2, 4, 1'b0, 1'b0, 2'd0};
        tv[6] = '{64'hA5_02_A5_A5_B4_00_00_00, 5, 1'b1, 2, 2, 1'b0, 1'b0, 2'd0};
        tv[7] = '{64'hA5_02_01_00_00_00_00_00, 3, 1'b0, 2, 1, 1'b1, 1'b1, 2'd3};

        bus.rx_data  = 8'h00;
        bus.rx_ready = 1'b0;
        bus.pl_ready = 1'b1;
        rst_l        = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_l = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            n = (tv[v].has_ck && !CK_EN) ? tv[v].nb - 1 : tv[v].nb;
            push_res(tv[v].exp_err, tv[v].exp_code);
            for (int i = 0; i < n; i++) begin
                b = tv[v].bytes[63 - 8*i -: 8];
                if (i >= tv[v].pl_first && i < tv[v].pl_first + tv[v].pl_n)
                    push_pl(b, (i == tv[v].pl_first + tv[v].pl_n - 1) && !tv[v].tmo);
                send_byte(b, 40);
            end
            repeat (tv[v].tmo ? TMO + 30 : 20) @(negedge clk);
            check_drained($sformatf("vec%0d", v));
        end

        // Reset in the middle of PAYLOAD: frame discarded without a pulse.
        push_pl(8'h11, 1'b0);
        send_byte(8'hA5, 40);
        send_byte(8'h03, 40);
        send_byte(8'h11, 40);
        repeat (3) @(negedge clk);
        rst_l = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);
        check_drained("midrst");
        push_res(1'b0, 2'd0);
        push_pl(8'h7E, 1'b1);
        send_byte(8'hA5, 40);
        send_byte(8'h01, 40);
        send_byte(8'h7E, 40);
        if (CK_EN) send_byte(8'h81, 40);
        repeat (20) @(negedge clk);
        check_drained("after_rst");

        // Downstream stalls for 500 cycles (longer than the timeout) mid-payload.
        push_res(1'b0, 2'd0);
        push_pl(8'h11, 1'b0);
        push_pl(8'h22, 1'b0);
        push_pl(8'h33, 1'b1);
        bus.pl_ready = 1'b0;
        send_byte(8'hA5, 40);
        send_byte(8'h03, 40);
        send_byte(8'h11, 40);
        bus.rx_data  = 8'h22;
        bus.rx_ready = 1'b1;
        acks = 0;
        repeat (500) begin
            @(negedge clk);
            if (bus.rx_ack) acks++;
        end
        chk("bp_ack_withheld", acks, 0);
        chk("bp_valid_held", int'(bus.pl_valid), 1);
        bus.pl_ready = 1'b1;
        n = 0;
        while (bus.rx_ack !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_ack_rise", int'(bus.rx_ack), 1);
        bus.rx_ready = 1'b0;
        @(negedge clk);
        chk("bp_ack_fall", int'(bus.rx_ack), 0);
        @(negedge clk);
        send_byte(8'h33, 40);
        if (CK_EN) send_byte(8'h97, 40);
        repeat (20) @(negedge clk);
        check_drained("bp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
